// File: rtl/alu_pkg.sv
// alu_pkg: shared width and opcode encodings for the 32-bit ALU
package alu_pkg;
  localparam int ALU_W = 32;
  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_SLL   = 4'h3,
    OP_SRL   = 4'h4,
    OP_SRA   = 4'h5,
    OP_XOR   = 4'h6,
    OP_AND   = 4'h7,
    OP_OR    = 4'h8,
    OP_NOR   = 4'h9,
    OP_NOT   = 4'hA,
    OP_SLT   = 4'hB,
    OP_SLTU  = 4'hC,
    OP_PASSA = 4'hD,
    OP_PASSB = 4'hE,
    OP_CLR   = 4'hF
  } alu_op_e;
endpackage

// File: rtl/alu_operand_gate.sv
// alu_operand_gate: forces a functional unit's operands to zero unless it is selected
module alu_operand_gate
  import alu_pkg::*;
#(
  parameter int WB = ALU_W
) (
  input  logic             i_sel,
  input  logic [ALU_W-1:0] i_a,
  input  logic [WB-1:0]    i_b,
  output logic [ALU_W-1:0] o_a,
  output logic [WB-1:0]    o_b
);
  assign o_a = i_a & {ALU_W{i_sel}};
  assign o_b = i_b & {WB{i_sel}};
endmodule

// File: rtl/alu_32bit_optimized.sv
// alu_32bit_optimized: registered 32-bit ALU with per-unit operand isolation and enable-gated outputs
module alu_32bit_optimized
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             enable,
  output logic [ALU_W-1:0] result,
  output logic             carry_out,
  output logic             zero_flag
);
  alu_op_e w_op;
  logic w_sel_add, w_sel_mul, w_sel_sh, w_sel_log, w_sub, w_slt, w_cy;
  logic [ALU_W-1:0] w_add_a, w_add_b, w_add_bx, w_mul_a, w_mul_b, w_sh_a, w_log_a, w_log_b, w_res;
  logic [4:0] w_sh_b;
  logic [ALU_W:0] w_sum;
  logic [2*ALU_W-1:0] w_prod;
  logic [ALU_W-1:0] r_result;
  logic r_carry, r_zero;
  assign w_op      = alu_op_e'(opcode);
  assign w_sel_add = enable & (w_op inside {OP_ADD, OP_SUB, OP_SLT, OP_SLTU});
  assign w_sel_mul = enable & (w_op == OP_MUL);
  assign w_sel_sh  = enable & (w_op inside {OP_SLL, OP_SRL, OP_SRA});
  assign w_sel_log = enable & (w_op inside {OP_XOR, OP_AND, OP_OR, OP_NOR, OP_NOT, OP_PASSA, OP_PASSB});
  assign w_sub     = w_sel_add & (w_op != OP_ADD);
  alu_operand_gate u_gate_add (.i_sel(w_sel_add), .i_a(A), .i_b(B), .o_a(w_add_a), .o_b(w_add_b));
  alu_operand_gate u_gate_mul (.i_sel(w_sel_mul), .i_a(A), .i_b(B), .o_a(w_mul_a), .o_b(w_mul_b));
  alu_operand_gate #(.WB(5)) u_gate_sh (.i_sel(w_sel_sh), .i_a(A), .i_b(B[4:0]), .o_a(w_sh_a), .o_b(w_sh_b));
  alu_operand_gate u_gate_log (.i_sel(w_sel_log), .i_a(A), .i_b(B), .o_a(w_log_a), .o_b(w_log_b));
  // Subtraction and both compares reuse the adder as A + ~B + 1; carry out means no borrow
  assign w_add_bx = w_sub ? ~w_add_b : w_add_b;
  assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_bx} + {{ALU_W{1'b0}}, w_sub};
  assign w_slt    = (w_add_a[ALU_W-1] ^ w_add_b[ALU_W-1]) ? w_add_a[ALU_W-1] : w_sum[ALU_W-1];
  assign w_prod   = {{ALU_W{1'b0}}, w_mul_a} * {{ALU_W{1'b0}}, w_mul_b};
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: {w_cy, w_res} = w_sum;
      OP_MUL:   begin w_res = w_prod[ALU_W-1:0]; w_cy = |w_prod[2*ALU_W-1:ALU_W]; end
      OP_SLL:   w_res = w_sh_a << w_sh_b;
      OP_SRL:   w_res = w_sh_a >> w_sh_b;
      OP_SRA:   w_res = $signed(w_sh_a) >>> w_sh_b;
      OP_XOR:   w_res = w_log_a ^ w_log_b;
      OP_AND:   w_res = w_log_a & w_log_b;
      OP_OR:    w_res = w_log_a | w_log_b;
      OP_NOR:   w_res = ~(w_log_a | w_log_b);
      OP_NOT:   w_res = ~w_log_a;
      OP_SLT:   w_res = {{(ALU_W-1){1'b0}}, w_slt};
      OP_SLTU:  w_res = {{(ALU_W-1){1'b0}}, ~w_sum[ALU_W]};
      OP_PASSA: w_res = w_log_a;
      OP_PASSB: w_res = w_log_b;
      default:  w_res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
    end else if (enable) begin
      r_result <= w_res;
      r_carry  <= w_cy;
      r_zero   <= (w_res == '0);
    end
  end
  assign result    = r_result;
  assign carry_out = r_carry;
  assign zero_flag = r_zero;
endmodule

// File: tb/tb_alu_32bit_optimized.sv
// tb_alu_32bit_optimized: directed and random checks of the registered ALU against an arithmetic reference model
module tb_alu_32bit_optimized;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [3:0]  opcode;
  logic        enable;
  logic [31:0] result;
  logic        carry_out, zero_flag;
  logic [31:0] e_res;
  logic        e_cy, e_z;
  int          n_total = 0;
  int          n_bad = 0;

  alu_32bit_optimized dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .opcode(opcode), .enable(enable),
    .result(result), .carry_out(carry_out), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    logic [31:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      4'd0:  begin wide = 64'(a) + 64'(b); r = wide[31:0]; c = wide[32]; end
      4'd1:  begin r = a - b; c = (a >= b); end
      4'd2:  begin wide = 64'(a) * 64'(b); r = wide[31:0]; c = (wide >= 64'h1_0000_0000); end
      4'd3:  r = a << b[4:0];
      4'd4:  r = a >> b[4:0];
      4'd5:  r = $signed(a) >>> b[4:0];
      4'd6:  r = a ^ b;
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = ~(a | b);
      4'd10: r = ~a;
      4'd11: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = (a < b) ? 32'd1 : 32'd0;
      4'd13: r = a;
      4'd14: r = b;
      default: r = 32'd0;
    endcase
    return {c, r};
  endfunction

  task automatic chk(input string tag);
    n_total += 3;
    assert (result === e_res) else begin n_bad++; $error("FAIL %s result got=%h exp=%h", tag, result, e_res); end
    assert (carry_out === e_cy) else begin n_bad++; $error("FAIL %s carry got=%b exp=%b", tag, carry_out, e_cy); end
    assert (zero_flag === e_z) else begin n_bad++; $error("FAIL %s zero got=%b exp=%b", tag, zero_flag, e_z); end
  endtask

  task automatic cyc(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic en);
    logic [32:0] m;
    A = a; B = b; opcode = op; enable = en;
    @(posedge clk);
    if (en) begin
      m = ref_alu(op, a, b);
      e_res = m[31:0];
      e_cy = m[32];
      e_z = (m[31:0] == 32'd0);
    end
    @(negedge clk);
    chk(tag);
  endtask

  task automatic expect_direct(input string tag, input logic [31:0] r, input logic c, input logic z);
    n_total += 3;
    assert (result === r) else begin n_bad++; $error("FAIL %s result got=%h exp=%h", tag, result, r); end
    assert (carry_out === c) else begin n_bad++; $error("FAIL %s carry got=%b exp=%b", tag, carry_out, c); end
    assert (zero_flag === z) else begin n_bad++; $error("FAIL %s zero got=%b exp=%b", tag, zero_flag, z); end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; opcode = '0; enable = 1'b0;
    e_res = 32'd0; e_cy = 1'b0; e_z = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset");
    rst_n = 1'b1;
    cyc("add", 4'd0, 32'h10, 32'h5, 1'b1);
    expect_direct("add_lit", 32'h15, 1'b0, 1'b0);
    cyc("sub", 4'd1, 32'h10, 32'h5, 1'b1);
    expect_direct("sub_lit", 32'hB, 1'b1, 1'b0);
    cyc("mul", 4'd2, 32'h10, 32'h5, 1'b1);
    expect_direct("mul_lit", 32'h50, 1'b0, 1'b0);
    cyc("and", 4'd7, 32'h10, 32'h5, 1'b1);
    expect_direct("and_lit", 32'h0, 1'b0, 1'b1);
    cyc("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
    expect_direct("add_wrap_lit", 32'h0, 1'b1, 1'b1);
    cyc("sub_borrow", 4'd1, 32'h3, 32'h5, 1'b1);
    expect_direct("sub_borrow_lit", 32'hFFFF_FFFE, 1'b0, 1'b0);
    cyc("mul_ovf", 4'd2, 32'h1_0000, 32'h1_0000, 1'b1);
    expect_direct("mul_ovf_lit", 32'h0, 1'b1, 1'b1);
    cyc("sra", 4'd5, 32'h8000_0000, 32'h21, 1'b1);
    expect_direct("sra_lit", 32'hC000_0000, 1'b0, 1'b0);
    cyc("slt", 4'd11, 32'hFFFF_FFFF, 32'h1, 1'b1);
    expect_direct("slt_lit", 32'h1, 1'b0, 1'b0);
    cyc("sltu", 4'd12, 32'hFFFF_FFFF, 32'h1, 1'b1);
    expect_direct("sltu_lit", 32'h0, 1'b0, 1'b1);
    cyc("hold_add", 4'd0, 32'h10, 32'h5, 1'b1);
    cyc("hold1", 4'd2, 32'h1234, 32'h99, 1'b0);
    cyc("hold2", 4'd15, 32'hDEAD_BEEF, 32'h0, 1'b0);
    cyc("hold3", 4'd9, 32'h0, 32'hFFFF, 1'b0);
    expect_direct("hold_lit", 32'h15, 1'b0, 1'b0);
    cyc("reenable", 4'd6, 32'hF0F0, 32'h0FF0, 1'b1);
    expect_direct("reenable_lit", 32'hFF00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 e_res = 32'd0; e_cy = 1'b0; e_z = 1'b1;
    chk("mid_reset");
    @(negedge clk);
    chk("reset_held");
    rst_n = 1'b1;
    cyc("first_after_reset", 4'd13, 32'hCAFE_0001, 32'h0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) ra = rb;
      cyc("rand", 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
